// File: rtl/signed_calc_pkg.sv
// Shared opcodes and FSM state encoding for the signed calculator unit.
package signed_calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_REM = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/signed_calc_iter.sv
// Iterative datapath: signed shift-add multiply and, with SIGNED_CALC_UNIT_DIV_EN,
// a restoring divide on magnitudes. One step per cycle, sequenced by the top FSM.
module signed_calc_iter #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
`ifdef SIGNED_CALC_UNIT_DIV_EN
  input  logic           is_rem,
`endif
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] res,
  output logic           last
);
  localparam int RW = 2 * W;
  localparam int CW = $clog2(W);

  logic [CW-1:0] cnt;
  logic [RW-1:0] acc, mcand, mul_nxt;
  logic [W-1:0]  mplr;

  assign last = (cnt == CW'(W - 1));

  // Multiplier MSB has weight -2^(W-1), so the last partial product is subtracted.
  always_comb begin
    mul_nxt = acc;
    if (mplr[0]) mul_nxt = last ? acc - mcand : acc + mcand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (load) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= {{W{a[W-1]}}, a};
      mplr  <= b;
    end else if (step) begin
      cnt   <= cnt + 1'b1;
      acc   <= mul_nxt;
      mcand <= {mcand[RW-2:0], 1'b0};
      mplr  <= {1'b0, mplr[W-1:1]};
    end
  end

`ifdef SIGNED_CALC_UNIT_DIV_EN
  logic          rem_mode, neg;
  logic [W-1:0]  q, dvs, sh, mag;
  logic [W-2:0]  rem;   // partial remainder stays below |B| <= 2^(W-1)
  logic [W:0]    diff;
  logic [RW-1:0] rem_res;

  always_comb begin
    sh      = {rem, q[W-1]};
    diff    = {1'b0, sh} - {1'b0, dvs};
    mag     = diff[W] ? sh : diff[W-1:0];
    rem_res = neg ? -{{W{1'b0}}, mag} : {{W{1'b0}}, mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_mode <= 1'b0;
      neg      <= 1'b0;
      q        <= '0;
      dvs      <= '0;
      rem      <= '0;
    end else if (load) begin
      rem_mode <= is_rem;
      neg      <= a[W-1];
      q        <= a[W-1] ? -a : a;
      dvs      <= b[W-1] ? -b : b;
      rem      <= '0;
    end else if (step) begin
      q   <= {q[W-2:0], ~diff[W]};
      rem <= mag[W-2:0];
    end
  end

  assign res = rem_mode ? rem_res : mul_nxt;
`else
  assign res = mul_nxt;
`endif

endmodule

// File: rtl/signed_calc_unit.sv
// Signed ADD/SUB/MUL/REM unit with valid/ready handshake and result flags.
// Define SIGNED_CALC_UNIT_DIV_EN to build the REM divider; otherwise REM reports EF.
module signed_calc_unit
  import signed_calc_pkg::*;
#(
  parameter int W  = 3,
  parameter int RW = 2 * W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  A,
  input  logic signed [W-1:0]  B,
  input  logic [1:0]           S,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [RW-1:0] R,
  output logic                 SF,
  output logic                 ZF,
  output logic                 DZF,
  output logic                 EF,
  output logic                 OF
);
  state_t        state;
  logic          accept, ld, last, upd, dz_new, ef_new, of_new;
  logic [RW-1:0] sa, sb, r_new, iter_res;
  logic [RW-W:0] hi;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;
  assign sa        = {{(RW-W){A[W-1]}}, A};
  assign sb        = {{(RW-W){B[W-1]}}, B};

  always_comb begin
    r_new  = '0;
    dz_new = 1'b0;
    ef_new = 1'b0;
    upd    = 1'b0;
    ld     = 1'b0;
    if (accept) begin
      case (S)
        OP_ADD: begin r_new = sa + sb; upd = 1'b1; end
        OP_SUB: begin r_new = sa - sb; upd = 1'b1; end
        OP_MUL: ld = 1'b1;
        default: begin
`ifdef SIGNED_CALC_UNIT_DIV_EN
          if (B == '0) begin
            dz_new = 1'b1;
            ef_new = 1'b1;
            upd    = 1'b1;
          end else begin
            ld = 1'b1;
          end
`else
          ef_new = 1'b1;
          upd    = 1'b1;
`endif
        end
      endcase
    end else if (state == BUSY && last) begin
      r_new = iter_res;
      upd   = 1'b1;
    end
  end

  // Fits in W signed bits only if everything from bit W-1 up is a pure sign extension.
  assign hi     = r_new[RW-1:W-1];
  assign of_new = !((&hi) || !(|hi));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      R     <= '0;
      SF    <= 1'b0;
      ZF    <= 1'b0;
      DZF   <= 1'b0;
      EF    <= 1'b0;
      OF    <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (in_valid) state <= ld ? BUSY : DONE;
        BUSY:    if (last) state <= DONE;
        DONE:    if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (upd) begin
        R   <= r_new;
        SF  <= r_new[RW-1];
        ZF  <= (r_new == '0);
        DZF <= dz_new;
        EF  <= ef_new;
        OF  <= of_new;
      end
    end
  end

  signed_calc_iter #(.W(W)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ld),
    .step   (state == BUSY),
`ifdef SIGNED_CALC_UNIT_DIV_EN
    .is_rem (S == OP_REM),
`endif
    .a      (A),
    .b      (B),
    .res    (iter_res),
    .last   (last)
  );

endmodule
